// File: rtl/grizzly_pkg.sv
// -----------------------------------------------------------------------------
// grizzly_pkg
// Shared definitions for the 8-bit core:
//   - register-file select codes for the special registers (SL, SH, SREG, PCL, PCH)
//   - state encoding of the CALL/RET sequencer
// -----------------------------------------------------------------------------
package grizzly_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   // Register-file selects for registers outside the general-purpose bank
   localparam logic [4:0] SEL_SL   = 5'b10000;
   localparam logic [4:0] SEL_SH   = 5'b10001;
   localparam logic [4:0] SEL_SREG = 5'b10010;
   localparam logic [4:0] SEL_PCL  = 5'b10011;
   localparam logic [4:0] SEL_PCH  = 5'b10100;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_RDSP    = 4'd1,
      ST_CAPSP   = 4'd2,
      ST_PUSH1   = 4'd3,
      ST_PUSH2   = 4'd4,
      ST_CALLFIN = 4'd5,
      ST_POP1    = 4'd6,
      ST_POP2    = 4'd7,
      ST_RETSP   = 4'd8,
      ST_RETFIN  = 4'd9
   } seq_state_e;

endpackage

// File: rtl/call_return_sequencer.sv
// -----------------------------------------------------------------------------
// call_return_sequencer
// Multi-cycle CALL/RET engine. Reads SP from the register file, pushes or pops
// the 16-bit return PC through data memory, writes the updated SP back and
// loads the PC.
//
// Ports
//   Clock, ResetN            clock, asynchronous active-low reset
//   CallReq, RetReq          start requests, sampled only when idle (CALL wins)
//   CallTarget, ReturnPC     PC to load / PC to push, latched on CALL accept
//   Busy, Done               busy from the cycle after accept through Done;
//                            Done pulses in the final cycle
//   RegS1Sel/RegS2Sel        register-file read selects (SL / SH)
//   RegS1Out/RegS2Out        register-file read data, one cycle after select
//   StackIn, StackInEnable   new SP value and its one-cycle write strobe
//   MemAddr, MemWData        data-memory address / write data
//   MemWe, MemRe, MemRData   write strobe, read strobe, read data (next cycle)
//   PCLoad, PCLoadValue      one-cycle PC load strobe and value
//   DbgState                 current sequencer state, for observation only
//
// Handshake: a request is taken on the rising edge that ends an IDLE cycle;
// requests at any other time are ignored and need not be held.
// All outputs are decoded from the state and the internal latches, so they
// drop to zero as soon as ResetN is asserted.
// -----------------------------------------------------------------------------
module call_return_sequencer
   import grizzly_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 8,
   parameter logic [4:0]  SP_LO_SEL = 5'b10000,
   parameter logic [4:0]  SP_HI_SEL = 5'b10001
) (
   input  logic              Clock,
   input  logic              ResetN,
   input  logic              CallReq,
   input  logic              RetReq,
   input  logic [ADDR_W-1:0] CallTarget,
   input  logic [ADDR_W-1:0] ReturnPC,
   output logic              Busy,
   output logic              Done,
   output logic [4:0]        RegS1Sel,
   output logic [4:0]        RegS2Sel,
   input  logic [DATA_W-1:0] RegS1Out,
   input  logic [DATA_W-1:0] RegS2Out,
   output logic [ADDR_W-1:0] StackIn,
   output logic              StackInEnable,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   output logic              MemWe,
   output logic              MemRe,
   input  logic [DATA_W-1:0] MemRData,
   output logic              PCLoad,
   output logic [ADDR_W-1:0] PCLoadValue,
   output seq_state_e        DbgState
);

   seq_state_e        r_state;
   seq_state_e        w_next;

   logic [ADDR_W-1:0] r_sp;
   logic [ADDR_W-1:0] r_ret_pc;
   logic [ADDR_W-1:0] r_target;
   logic [DATA_W-1:0] r_pch;
   logic [DATA_W-1:0] r_pcl;
   logic              r_is_call;

   // Stack address arithmetic wraps modulo 2^ADDR_W by construction
   logic [ADDR_W-1:0] w_sp_m1;
   logic [ADDR_W-1:0] w_sp_m2;
   logic [ADDR_W-1:0] w_sp_p1;
   logic [ADDR_W-1:0] w_sp_p2;

   assign w_sp_m1  = r_sp - ADDR_W'(1);
   assign w_sp_m2  = r_sp - ADDR_W'(2);
   assign w_sp_p1  = r_sp + ADDR_W'(1);
   assign w_sp_p2  = r_sp + ADDR_W'(2);
   assign DbgState = r_state;

   // State register
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Operand latches
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_sp      <= '0;
         r_ret_pc  <= '0;
         r_target  <= '0;
         r_pch     <= '0;
         r_pcl     <= '0;
         r_is_call <= 1'b0;
      end else begin
         if (r_state == ST_IDLE) begin
            if (CallReq) begin
               r_ret_pc  <= ReturnPC;
               r_target  <= CallTarget;
               r_is_call <= 1'b1;
            end else if (RetReq) begin
               r_is_call <= 1'b0;
            end
         end
         // Register-file data for the RDSP selects is valid during CAPSP
         if (r_state == ST_CAPSP) begin
            r_sp <= {RegS2Out, RegS1Out};
         end
         // Memory data arrives one cycle after its read strobe
         if (r_state == ST_POP2) begin
            r_pch <= MemRData;
         end
         if (r_state == ST_RETSP) begin
            r_pcl <= MemRData;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (CallReq || RetReq) w_next = ST_RDSP;
         ST_RDSP:    w_next = ST_CAPSP;
         ST_CAPSP:   w_next = r_is_call ? ST_PUSH1 : ST_POP1;
         ST_PUSH1:   w_next = ST_PUSH2;
         ST_PUSH2:   w_next = ST_CALLFIN;
         ST_CALLFIN: w_next = ST_IDLE;
         ST_POP1:    w_next = ST_POP2;
         ST_POP2:    w_next = ST_RETSP;
         ST_RETSP:   w_next = ST_RETFIN;
         ST_RETFIN:  w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      Busy          = (r_state != ST_IDLE);
      Done          = 1'b0;
      RegS1Sel      = '0;
      RegS2Sel      = '0;
      StackIn       = '0;
      StackInEnable = 1'b0;
      MemAddr       = '0;
      MemWData      = '0;
      MemWe         = 1'b0;
      MemRe         = 1'b0;
      PCLoad        = 1'b0;
      PCLoadValue   = '0;
      case (r_state)
         ST_RDSP, ST_CAPSP: begin
            RegS1Sel = SP_LO_SEL;
            RegS2Sel = SP_HI_SEL;
         end
         // Low byte first at SP, high byte at SP-1 (post-decrement push)
         ST_PUSH1: begin
            MemAddr  = r_sp;
            MemWData = r_ret_pc[DATA_W-1:0];
            MemWe    = 1'b1;
         end
         ST_PUSH2: begin
            MemAddr  = w_sp_m1;
            MemWData = r_ret_pc[ADDR_W-1:DATA_W];
            MemWe    = 1'b1;
         end
         ST_CALLFIN: begin
            StackIn       = w_sp_m2;
            StackInEnable = 1'b1;
            PCLoad        = 1'b1;
            PCLoadValue   = r_target;
            Done          = 1'b1;
         end
         // Pre-increment pop: high byte sits at SP+1, low byte at SP+2
         ST_POP1: begin
            MemAddr = w_sp_p1;
            MemRe   = 1'b1;
         end
         ST_POP2: begin
            MemAddr = w_sp_p2;
            MemRe   = 1'b1;
         end
         ST_RETSP: begin
            StackIn       = w_sp_p2;
            StackInEnable = 1'b1;
         end
         ST_RETFIN: begin
            PCLoad      = 1'b1;
            PCLoadValue = {r_pch, r_pcl};
            Done        = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
